// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receiver slice.
//   uart_rx_state_t : receiver FSM state encoding (also exported on the
//                     receiver's debug state output)
//   UART_DATA_BITS  : payload bits per frame
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Consumer-side read handshake of the UART receiver.
//   rreq  : consumer requests a byte
//   rgnt  : byte transferred this cycle (rreq & FIFO non-empty)
//   rdata : head-of-FIFO byte, valid whenever the FIFO is non-empty
// Handshake: a byte moves exactly in a cycle where rgnt is 1; rgnt is a pure
// function of rreq and the FIFO empty flag, and rdata advances to the next
// entry in the cycle after a grant.
//   master : the consumer (drives rreq)
//   slave  : the receiver (drives rgnt/rdata)
// ---------------------------------------------------------------------------
interface uart_rx_if;

    logic       rreq;
    logic       rgnt;
    logic [7:0] rdata;

    modport master (
        output rreq,
        input  rgnt,
        input  rdata
    );

    modport slave (
        input  rreq,
        output rgnt,
        output rdata
    );

endinterface : uart_rx_if

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word fall-through FIFO over a synchronous-read RAM with
// 2^ASIZE entries (2^ASIZE - 1 usable).
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write request (dropped when full)
//   i_push_data  : write data
//   i_pop        : read request (ignored when empty)
//   o_full       : wr_ptr + 1 == rd_ptr
//   o_empty      : no readable entry
//   o_data       : head entry; 0 while empty
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int ASIZE = 9,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0]    r_mem [2**ASIZE];
    logic [DW-1:0]    r_rd_data;
    logic [ASIZE-1:0] r_wr_ptr;
    logic [ASIZE-1:0] r_wr_ptr_vis;
    logic [ASIZE-1:0] r_rd_ptr;

    logic [ASIZE-1:0] w_rd_ptr_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Fullness uses the live write pointer so a push is judged before any
    // same-cycle pop. Emptiness uses a one-cycle-late copy: the read register
    // only picks up a freshly written entry one cycle after the write, so the
    // entry is advertised together with its data.
    assign w_full    = (ASIZE'(r_wr_ptr + 1'b1) == r_rd_ptr);
    assign w_empty   = (r_wr_ptr_vis == r_rd_ptr);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    assign w_rd_ptr_nxt = r_rd_ptr + ASIZE'(w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_wr_ptr_vis <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_wr_ptr_vis <= r_wr_ptr;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // RAM and its read register; the read address looks ahead by the pop so
    // the next entry is presented the cycle after a grant.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
        r_rd_data <= r_mem[w_rd_ptr_nxt];
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_data  = w_empty ? '0 : r_rd_data;

endmodule : uart_rx_fifo

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: mid-bit sampling of an asynchronous line, 8N1 framing
// (8E1/8O1 when UART_RX_PARITY_EN is defined), good bytes buffered in an
// internal FWFT FIFO drained through a rreq/rgnt handshake.
// Build option: `define UART_RX_PARITY_EN adds a parity bit to the frame,
// the PARITY state and the o_parity_err port.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_uart_rx      : serial line, idle high
//   rx_bus         : read handshake (slave side of uart_rx_if)
//   o_frame_err    : 1-cycle pulse, stop bit sampled 0
//   o_overflow     : 1-cycle pulse, good byte dropped on a full FIFO
//   o_parity_err   : 1-cycle pulse, parity mismatch (parity builds only)
//   o_state        : current FSM state (debug)
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int UART_CLK_DIV = 434,
    parameter int FIFO_ASIZE   = 9,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_uart_rx,
    uart_rx_if.slave       rx_bus,
    output logic           o_frame_err,
    output logic           o_overflow,
`ifdef UART_RX_PARITY_EN
    output logic           o_parity_err,
`endif
    output uart_rx_state_t o_state
);

    localparam int            CW        = $clog2(UART_CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(UART_CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(UART_CLK_DIV / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    // Synchronizer, reset to the idle level so reset release is not a start.
    logic r_rx_meta;
    logic r_rx_s;

    uart_rx_state_t            r_state;
    logic [CW-1:0]             r_div_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_push;
    logic                      r_frame_err;

    uart_rx_state_t            w_state_nxt;
    logic [CW-1:0]             w_div_cnt_nxt;
    logic [2:0]                w_bit_cnt_nxt;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_push_nxt;
    logic                      w_frame_err_nxt;
    logic                      w_par_ok;
    logic                      w_tick;
    logic                      w_half_tick;
    logic                      w_full;
    logic                      w_empty;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_par_bit_nxt;
    logic w_parity_err_nxt;

    assign w_par_ok = ~(^r_shift ^ r_par_bit ^ PARITY_ODD);
`else
    // PARITY_ODD has no effect in an 8N1 build.
    logic w_unused_parity_odd;
    assign w_unused_parity_odd = PARITY_ODD;
    assign w_par_ok            = 1'b1;
`endif

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_half_tick = (r_div_cnt == HALF_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_push       <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_push       <= w_push_nxt;
            r_frame_err  <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= w_par_bit_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_div_cnt_nxt    = r_div_cnt + 1'b1;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_push_nxt       = 1'b0;
        w_frame_err_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_nxt    = r_par_bit;
        w_parity_err_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_div_cnt_nxt = '0;
                if (!r_rx_s) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = START;
                end
            end
            START: begin
                // Half a bit after the falling edge; a high line here means
                // the edge was a glitch.
                if (w_half_tick) begin
                    w_div_cnt_nxt = '0;
                    w_state_nxt   = r_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_div_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_div_cnt_nxt = '0;
                    w_par_bit_nxt = r_rx_s;
                    w_state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_div_cnt_nxt = '0;
                    if (r_rx_s) begin
                        if (w_par_ok) begin
                            w_push_nxt = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else begin
                            w_parity_err_nxt = 1'b1;
                        end
`endif
                        w_state_nxt = IDLE;
                    end else begin
                        // Framing error wins over parity; hold off until the
                        // line returns high so a break reports only once.
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                w_div_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_div_cnt_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // r_shift is stable during the push cycle (the next frame cannot reach
    // a data sample that soon), so it feeds the FIFO directly.
    uart_rx_fifo #(
        .ASIZE (FIFO_ASIZE),
        .DW    (UART_DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_push),
        .i_push_data (r_shift),
        .i_pop       (rx_bus.rgnt),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_data      (rx_bus.rdata)
    );

    assign rx_bus.rgnt  = rx_bus.rreq & ~w_empty;
    assign o_overflow   = r_push & w_full;
    assign o_frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif
    assign o_state      = r_state;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx at UART_CLK_DIV=16, FIFO_ASIZE=2 (3 usable
// entries), even parity when UART_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DIV   = 16;
    localparam int ASIZE = 2;
    localparam bit ODD   = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic rx_line;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if rx_bus ();

    logic           frame_err;
    logic           overflow;
    logic           parity_err;
    uart_rx_state_t dut_state;

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    uart_rx #(
        .UART_CLK_DIV (DIV),
        .FIFO_ASIZE   (ASIZE),
        .PARITY_ODD   (ODD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_uart_rx    (rx_line),
        .rx_bus       (rx_bus),
        .o_frame_err  (frame_err),
        .o_overflow   (overflow),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (parity_err),
`endif
        .o_state      (dut_state)
    );

    // ---------------- monitor / scoreboard ----------------
    int         n_assert;
    int         n_fail;
    int         fe_cnt;
    int         ov_cnt;
    int         pe_cnt;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (frame_err)   fe_cnt++;
        if (overflow)    ov_cnt++;
        if (parity_err)  pe_cnt++;
        if (rx_bus.rgnt) got_q.push_back(rx_bus.rdata);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare everything granted so far against the expected byte list.
    task automatic check_bytes(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx_line = b;
        repeat (DIV - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ^d ^ ODD;
    endfunction

    int fe_base;
    int ov_base;
    int pe_base;

    // ---------------- directed sequence ----------------
    initial begin
        n_assert    = 0;
        n_fail      = 0;
        fe_cnt      = 0;
        ov_cnt      = 0;
        pe_cnt      = 0;
        rst_n       = 1'b0;
        rx_line     = 1'b1;
        rx_bus.rreq = 1'b1;

        // Reset values
        idle(3);
        @(negedge clk);
        check("rst_rgnt", 32'(rx_bus.rgnt), 32'h0);
        check("rst_rdata", 32'(rx_bus.rdata), 32'h00);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_state", 32'(dut_state), 32'(IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // Single frame 0xA5, consumer always ready
        fe_base = fe_cnt; ov_base = ov_cnt; pe_base = pe_cnt;
        send_frame(8'hA5, good_par(8'hA5), 1'b1);
        exp_q.push_back(8'hA5);
        idle(20);
        @(negedge clk);
        check_bytes("a5");
        check("a5_frame_err", 32'(fe_cnt - fe_base), 32'd0);
        check("a5_overflow", 32'(ov_cnt - ov_base), 32'd0);
        check("a5_parity_err", 32'(pe_cnt - pe_base), 32'd0);

        // 5-cycle low glitch
        fe_base = fe_cnt;
        @(posedge clk);
        #1 rx_line = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("glitch_in_start", 32'(dut_state), 32'(START));
        @(posedge clk);
        #1 rx_line = 1'b1;
        idle(30);
        @(negedge clk);
        check("glitch_state", 32'(dut_state), 32'(IDLE));
        check("glitch_frame_err", 32'(fe_cnt - fe_base), 32'd0);
        check_bytes("glitch");

        // 0x3C with stop 0, then break for 40 bit times
        fe_base = fe_cnt;
        send_frame(8'h3C, good_par(8'h3C), 1'b0);
        repeat (40 * DIV) @(posedge clk);
        @(negedge clk);
        check("break_state", 32'(dut_state), 32'(WAIT_HIGH));
        @(posedge clk);
        #1 rx_line = 1'b1;
        idle(20);
        @(negedge clk);
        check("break_frame_err", 32'(fe_cnt - fe_base), 32'd1);
        check("break_state_idle", 32'(dut_state), 32'(IDLE));
        check_bytes("break");
        send_frame(8'h11, good_par(8'h11), 1'b1);
        exp_q.push_back(8'h11);
        idle(20);
        @(negedge clk);
        check_bytes("after_break");
        check("after_break_frame_err", 32'(fe_cnt - fe_base), 32'd1);

        // Overflow: 5 back-to-back frames into a 3-entry FIFO
        @(posedge clk);
        #1 rx_bus.rreq = 1'b0;
        ov_base = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), good_par(8'(i)), 1'b1);
        end
        idle(20);
        @(negedge clk);
        check("ovf_pulses", 32'(ov_cnt - ov_base), 32'd2);
        check("ovf_head", 32'(rx_bus.rdata), 32'h01);
        check("ovf_rgnt_idle", 32'(rx_bus.rgnt), 32'h0);
        @(posedge clk);
        #1 rx_bus.rreq = 1'b1;
        idle(10);
        @(negedge clk);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        check_bytes("ovf_drain");
        check("ovf_rgnt_empty", 32'(rx_bus.rgnt), 32'h0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: even parity bit must be 1
        pe_base = pe_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        idle(20);
        @(negedge clk);
        check("par_bad_pulse", 32'(pe_cnt - pe_base), 32'd1);
        check_bytes("par_bad");
        send_frame(8'h07, 1'b1, 1'b1);
        exp_q.push_back(8'h07);
        idle(20);
        @(negedge clk);
        check_bytes("par_good");
        check("par_good_pulse", 32'(pe_cnt - pe_base), 32'd1);
`endif

        // Reset during data bit 4 with a byte already buffered
        @(posedge clk);
        #1 rx_bus.rreq = 1'b0;
        send_frame(8'h77, good_par(8'h77), 1'b1);
        idle(20);
        @(negedge clk);
        check("pre_rst_head", 32'(rx_bus.rdata), 32'h77);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        @(posedge clk);
        #1 rx_line = 1'b0;
        repeat (DIV / 2) @(posedge clk);
        #1;
        rst_n       = 1'b0;
        rx_line     = 1'b1;
        rx_bus.rreq = 1'b1;
        @(negedge clk);
        check("midrst_rgnt", 32'(rx_bus.rgnt), 32'h0);
        check("midrst_rdata", 32'(rx_bus.rdata), 32'h00);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);
        check("midrst_parity_err", 32'(parity_err), 32'h0);
        check("midrst_state", 32'(dut_state), 32'(IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        send_frame(8'h5A, good_par(8'h5A), 1'b1);
        exp_q.push_back(8'h5A);
        idle(20);
        @(negedge clk);
        check_bytes("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
# uart_rx

UART receiver, the counterpart of the team's FIFO-buffered UART transmitter. Samples an asynchronous `i_uart_rx` line at mid-bit using a clock-divider counter and assembles 8N1 frames (8E1/8O1 when parity is compiled in). Pushes each good byte into an internal 2^FIFO_ASIZE-entry FIFO. User logic drains the FIFO with a `rreq`/`rgnt` handshake that mirrors the transmitter's `wreq`/`wgnt`.

## Interface
- UART_CLK_DIV, 434: clk cycles per bit (baud = clk/UART_CLK_DIV); legal range ≥ 8.
- FIFO_ASIZE, 9: FIFO address width; usable depth 2^FIFO_ASIZE − 1 bytes.
- PARITY_ODD, 0: 0 = even parity, 1 = odd. Only meaningful with UART_RX_PARITY_EN.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_uart_rx  input  1  asynchronous serial line; idle high.
- rreq  input  1  consumer requests a byte.
- rgnt  output  1  = rreq & FIFO non-empty; byte transferred this cycle.
- rdata  output  8  head-of-FIFO byte; valid whenever FIFO non-empty (first-word fall-through).
- o_frame_err  output  1  one-cycle pulse; stop bit sampled 0.
- o_overflow  output  1  one-cycle pulse; good byte dropped because the FIFO was full.
- o_parity_err  output  1  one-cycle pulse; parity mismatch. Present only with UART_RX_PARITY_EN.

## Operation
- Input path:
  - 2-flop synchronizer on i_uart_rx; both flops reset to 1.
  - The FSM sees only the synchronized bit `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: when rx_s == 0, clear the bit counter and go to START.
- START: wait UART_CLK_DIV/2 − 1 cycles (integer division), then sample rx_s.
  - Sample 0: go to DATA.
  - Sample 1: treat as a glitch and return to IDLE. No flag is raised.
- DATA: sample every UART_CLK_DIV cycles, 8 samples, LSB first, shifted into an 8-bit shift register.
- PARITY: one sample after DATA.
  - Check: XOR of data bits ^ parity bit ^ PARITY_ODD must be 0.
- STOP: one sample after DATA (or PARITY).
  - Stop == 1 and parity OK: push the byte. Go to IDLE. The next start edge is accepted immediately, so back-to-back frames need no gap.
  - Stop == 1 and parity bad: pulse o_parity_err, discard the byte, go to IDLE.
  - Stop == 0: pulse o_frame_err, discard the byte (parity is not reported), go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. A break condition therefore yields exactly one o_frame_err.
- FIFO: RAM plus write and read pointers (wrap modulo 2^FIFO_ASIZE).
  - Full: wr_ptr + 1 == rd_ptr. A push while full drops the byte, pulses o_overflow, and leaves the pointers unchanged.
  - Empty: wr_ptr == rd_ptr. rgnt stays 0 whatever rreq is.
- Simultaneous push and pop in the same cycle: both take effect; the count is unchanged.
- A push while full with a same-cycle pop is still dropped. Fullness is evaluated before the pop.
- Reset mid-frame: FSM returns to IDLE, FIFO empties, and the partial byte is lost. After release, a line held low is treated as a new start.

## Timing
- Reset values: rgnt 0, rdata 8'h00, o_frame_err 0, o_overflow 0, o_parity_err 0. FSM in IDLE, pointers 0.
- Input latency: 2 cycles of synchronizer.
- Sample points: start at edge + UART_CLK_DIV/2; data bit k at edge + UART_CLK_DIV/2 + (k+1)·UART_CLK_DIV.
- Push latency: the byte is written 1 cycle after the stop sample. rdata/rgnt-eligible no later than 3 cycles after the stop sample.
- rgnt is combinational from rreq and the empty flag. rdata updates to the next entry the cycle after a rgnt.
- Error pulses assert exactly 1 cycle after the stop (or parity-decision) sample.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is start + 8 data + parity + stop.
  - The PARITY state and o_parity_err port exist.
- Not defined:
  - 8N1 only; PARITY_ODD is ignored.
  - No o_parity_err port, no PARITY state.

## Structure
- Package `uart_pkg` holds:
  - `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Constant UART_DATA_BITS = 8.
- One sub-module: `uart_rx_fifo`.
  - Dual-pointer FWFT FIFO over a synchronous-read RAM.
  - Ports: push/pop, full/empty, data.
- The FSM, divider counter and synchronizer stay in `uart_rx`.

## Test plan
- Single frame 0xA5 at UART_CLK_DIV=16 → one entry. With rreq=1: rgnt for 1 cycle with rdata=0xA5; no error pulses.
- Low glitch of 5 cycles at UART_CLK_DIV=16 → no byte, no o_frame_err, FSM back to IDLE.
- Frame 0x3C with stop bit 0, then line held low for 40 bits → exactly one o_frame_err pulse, FIFO empty. A following valid 0x11 is received.
- FIFO_ASIZE=2 with rreq=0: send 0x01..0x05 back-to-back.
  - Expected: 3 bytes stored, 2 o_overflow pulses.
  - Drain yields 0x01, 0x02, 0x03.
- With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity 0 → o_parity_err, no byte. Send 0x07 with parity 1 → byte 0x07 stored.
- Assert rst_n low during data bit 4 of a frame → all outputs at reset values. The next full frame 0x5A is received correctly.
